moa_nxw_pipe_fa42: RTL and testbench

//  Parametrised, pipelined multi-operand adder. Sums N unsigned W-bit operands

---
 rtl/moa_nxw_pipe_fa42_pkg.sv | 31 +++
 rtl/moa_nxw_pipe_fa42_fa42_row.sv | 32 +++
 rtl/moa_nxw_pipe_fa42.sv | 127 ++++++++++++
 tb/tb_moa_nxw_pipe_fa42.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/moa_nxw_pipe_fa42_pkg.sv
// Shared sizing helpers for the multi-operand 4:2 adder: tree depth, widths and
// pipeline latency, used by the RTL and by anything that needs to predict its timing.
package moa_nxw_pipe_fa42_pkg;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  // Compressor levels needed to bring N rows down to 2.
  function automatic int lvl_of(input int n);
    return clog2(n) - 1;
  endfunction

  function automatic int tree_w(input int n, input int w);
    return w + clog2(n);
  endfunction

  // A register follows every re-th level and always the last one.
  function automatic bit reg_after(input int l, input int lvl, input int re);
    return ((l % re) == 0) || (l == lvl);
  endfunction

  // Accept edge to output register, counting the accept edge as the first advance.
  function automatic int lat_of(input int n, input int re);
    return (lvl_of(n) + re - 1) / re + 1;
  endfunction

endpackage

// File: rtl/moa_nxw_pipe_fa42_fa42_row.sv
// Combinational row of 4:2 compressors: four WIDTH-bit rows in, a sum row and a
// carry row out, each one bit wider, with a+b+c+d == s+cy exactly.
module fa42_row
  import moa_nxw_pipe_fa42_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH:0]   s,
  output logic [WIDTH:0]   cy
);

  logic [WIDTH-1:0] s1;
  logic [WIDTH-1:0] co;
  logic [WIDTH-1:0] ci;
  logic [WIDTH-1:0] s2;
  logic [WIDTH-1:0] c2;

  // The lateral carry depends only on a,b,c, so nothing ripples across the row.
  assign s1 = a ^ b ^ c;
  assign co = (a & b) | (a & c) | (b & c);
  assign ci = co << 1;
  assign s2 = s1 ^ d ^ ci;
  assign c2 = (s1 & d) | (s1 & ci) | (d & ci);

  assign s  = {co[WIDTH-1], s2};
  assign cy = {c2, 1'b0};

endmodule

// File: rtl/moa_nxw_pipe_fa42.sv
// Pipelined N-operand unsigned adder: 4:2 compressor tree, final CPA, and an output
// stage with valid/ready backpressure and per-burst accumulation.
module moa_nxw_pipe_fa42
  import moa_nxw_pipe_fa42_pkg::*;
#(
  parameter int N         = 8,
  parameter int W         = 8,
  parameter int REG_EVERY = 1,
  parameter int ACC_X     = 8,
  localparam int SUM_W    = W + clog2(N) + ACC_X
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N*W-1:0]     x_flat,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_acc,
  input  logic               in_last,
  output logic [SUM_W-1:0]   sum,
  output logic               out_valid,
  input  logic               out_ready
);

  localparam int LVL    = lvl_of(N);
  localparam int TREE_W = tree_w(N, W);

  logic adv;
  assign adv      = !out_valid | out_ready;
  assign in_ready = adv;

  for (genvar l = 0; l <= LVL; l++) begin : g_lvl
    logic [TREE_W-1:0] rows [N];
    logic              vld;
    logic              acc;
    logic              last;

    if (l == 0) begin : g_in
      for (genvar j = 0; j < N; j++) begin : g_op
        assign rows[j] = TREE_W'(x_flat[j*W +: W]);
      end
      assign vld  = in_valid;
      assign acc  = in_acc;
      assign last = in_acc & in_last;
    end else begin : g_cmp
      localparam int CW = W + l - 1;
      localparam int NR = N >> l;
      logic [TREE_W-1:0] nxt [N];

      // Output rows 2g/2g+1 come from input rows 4g..4g+3; unused lanes stay zero.
      for (genvar j = 0; j < N; j++) begin : g_row
        if (j < NR && (j % 2) == 0) begin : g_cell
          logic [CW:0] s;
          logic [CW:0] cy;
          fa42_row #(.WIDTH(CW)) u_row (
            .a  (g_lvl[l-1].rows[2*j][CW-1:0]),
            .b  (g_lvl[l-1].rows[2*j+1][CW-1:0]),
            .c  (g_lvl[l-1].rows[2*j+2][CW-1:0]),
            .d  (g_lvl[l-1].rows[2*j+3][CW-1:0]),
            .s  (s),
            .cy (cy)
          );
          assign nxt[j]   = TREE_W'(s);
          assign nxt[j+1] = TREE_W'(cy);
        end else if (j >= NR) begin : g_pad
          assign nxt[j] = '0;
        end
      end

      if (reg_after(l, LVL, REG_EVERY)) begin : g_reg
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            vld  <= 1'b0;
            acc  <= 1'b0;
            last <= 1'b0;
            for (int j = 0; j < N; j++) rows[j] <= '0;
          end else if (adv) begin
            vld  <= g_lvl[l-1].vld;
            acc  <= g_lvl[l-1].acc;
            last <= g_lvl[l-1].last;
            for (int j = 0; j < N; j++) rows[j] <= nxt[j];
          end
        end
      end else begin : g_wire
        assign rows = nxt;
        assign vld  = g_lvl[l-1].vld;
        assign acc  = g_lvl[l-1].acc;
        assign last = g_lvl[l-1].last;
      end
    end
  end

  logic [TREE_W-1:0] tree_sum;
  logic [SUM_W-1:0]  tree_ext;
  logic [SUM_W-1:0]  acc_reg;
  logic [SUM_W-1:0]  base;
  logic              acc_active;

  assign tree_sum = g_lvl[LVL].rows[0] + g_lvl[LVL].rows[1];
  assign tree_ext = SUM_W'(tree_sum);
  assign base     = acc_active ? acc_reg : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum        <= '0;
      out_valid  <= 1'b0;
      acc_reg    <= '0;
      acc_active <= 1'b0;
    end else if (adv) begin
      out_valid <= 1'b0;
      if (g_lvl[LVL].vld) begin
        if (!g_lvl[LVL].acc) begin
          sum       <= tree_ext;
          out_valid <= 1'b1;
        end else if (!g_lvl[LVL].last) begin
          acc_reg    <= base + tree_ext;
          acc_active <= 1'b1;
        end else begin
          sum        <= base + tree_ext;
          out_valid  <= 1'b1;
          acc_reg    <= '0;
          acc_active <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_moa_nxw_pipe_fa42.sv
// Scoreboard bench for moa_nxw_pipe_fa42 over several N/W/REG_EVERY/ACC_X configurations;
// expected sums come from plain arithmetic on the accepted operands.
module tb_moa_nxw_pipe_fa42;
  import moa_nxw_pipe_fa42_pkg::*;

  localparam int NC = 3;
  localparam int C_N   [NC] = '{8, 4, 16};
  localparam int C_W   [NC] = '{8, 2, 8};
  localparam int C_RE  [NC] = '{1, 2, 2};
  localparam int C_AX  [NC] = '{8, 0, 8};
  localparam int C_LAT [NC] = '{3, 2, 3};
  localparam int K     [8]  = '{1, 2, 3, 4, 4, 3, 2, 1};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;
  int n_done = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input longint unsigned act, input longint unsigned exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  for (genvar g = 0; g < NC; g++) begin : g_cfg
    localparam int N   = C_N[g];
    localparam int W   = C_W[g];
    localparam int RE  = C_RE[g];
    localparam int AX  = C_AX[g];
    localparam int SW  = W + clog2(N) + AX;
    localparam int LAT = lat_of(N, RE);
    localparam longint unsigned SMASK = (64'd1 << SW) - 1;
    localparam logic [W-1:0] WMAX = '1;

    logic           rst_n;
    logic [N*W-1:0] x_flat;
    logic           in_valid, in_ready, in_acc, in_last;
    logic [SW-1:0]  sum;
    logic           out_valid, out_ready;

    moa_nxw_pipe_fa42 #(.N(N), .W(W), .REG_EVERY(RE), .ACC_X(AX)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .x_flat    (x_flat),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_acc    (in_acc),
      .in_last   (in_last),
      .sum       (sum),
      .out_valid (out_valid),
      .out_ready (out_ready)
    );

    longint unsigned exp_q [$];
    longint unsigned acc_m = 0;
    int  n_pop   = 0;
    int  pop_cyc = 0;
    bit  rnd_bp  = 0;

    task automatic ck(input string nm, input longint unsigned act, input longint unsigned exp);
      chk($sformatf("cfg%0d %s", g, nm), act, exp);
    endtask

    always @(negedge clk) begin
      if (out_valid && out_ready) begin
        n_pop++;
        pop_cyc = cyc;
        if (exp_q.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL cfg%0d unexpected output: got %0d, expected none", g, sum);
        end else begin
          ck("result", longint'(sum), exp_q.pop_front());
        end
      end
    end

    task automatic tick();
      @(posedge clk);
      #1;
      if (rnd_bp) out_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic model(input logic [N*W-1:0] x, input bit a, input bit l);
      longint unsigned t;
      t = 0;
      for (int i = 0; i < N; i++) t += longint'(x[i*W +: W]);
      if (!a) exp_q.push_back(t & SMASK);
      else if (!l) acc_m = (acc_m + t) & SMASK;
      else begin
        exp_q.push_back((acc_m + t) & SMASK);
        acc_m = 0;
      end
    endtask

    task automatic send(input logic [N*W-1:0] x, input bit a, input bit l);
      bit ok;
      x_flat = x; in_acc = a; in_last = l; in_valid = 1'b1;
      for (int t = 0; t < 200; t++) begin
        @(negedge clk);
        ok = in_ready;
        tick();
        if (ok) begin
          model(x, a, l);
          in_valid = 1'b0;
          return;
        end
      end
      checks++;
      fails++;
      $display("FAIL cfg%0d send timeout: got in_ready=0, expected accept", g);
      in_valid = 1'b0;
    endtask

    task automatic drain();
      rnd_bp = 0;
      out_ready = 1'b1;
      for (int t = 0; t < 500 && exp_q.size() != 0; t++) tick();
      repeat (2) tick();
      ck("drain queue empty", exp_q.size(), 0);
    endtask

    function automatic logic [N*W-1:0] fill(input logic [W-1:0] v);
      logic [N*W-1:0] r;
      for (int i = 0; i < N; i++) r[i*W +: W] = v;
      return r;
    endfunction

    function automatic logic [N*W-1:0] count_beat(input int cnt);
      logic [N*W-1:0] r;
      for (int i = 0; i < N; i++) r[i*W +: W] = W'(cnt + K[i % 8]);
      return r;
    endfunction

    initial begin : stim
      int p0, a0, saved;
      bit open, a, l;
      logic [N*W-1:0] x;
      rst_n = 0; in_valid = 0; in_acc = 0; in_last = 0; x_flat = '0; out_ready = 1;
      repeat (2) @(posedge clk);
      #1;
      ck("reset out_valid", out_valid, 0);
      ck("reset sum", sum, 0);
      ck("reset in_ready", in_ready, 1);
      rst_n = 1;
      tick();

      // Single all-max beat: latency in advancing edges, accept edge counted.
      p0 = n_pop;
      send(fill(WMAX), 0, 0);
      a0 = cyc;
      for (int t = 0; t < 20 && n_pop == p0; t++) tick();
      ck("single beat outputs", n_pop - p0, 1);
      ck("latency vs table", pop_cyc - a0 + 1, C_LAT[g]);
      ck("latency vs pkg", pop_cyc - a0 + 1, LAT);
      drain();

      // Counting stream, back to back.
      p0 = n_pop;
      send(count_beat(0), 0, 0);
      a0 = cyc;
      for (int c = 1; c < 256; c++) send(count_beat(c), 0, 0);
      ck("stream accept span", cyc - a0, 255);
      drain();
      ck("stream count", n_pop - p0, 256);
      ck("stream output span", pop_cyc - a0, 255 + LAT - 1);

      // Stream with a 5-cycle consumer stall in the middle.
      p0 = n_pop;
      for (int c = 0; c < 20; c++) begin
        if (c == 10) begin
          x = count_beat(c + 40);
          x_flat = x; in_acc = 0; in_last = 0; in_valid = 1;
          out_ready = 0;
          saved = int'(sum);
          ck("stall out_valid", out_valid, 1);
          repeat (5) begin
            @(negedge clk);
            ck("stall in_ready", in_ready, 0);
            ck("stall sum hold", sum, saved);
            tick();
          end
          out_ready = 1;
          send(x, 0, 0);
        end else begin
          send(count_beat(c + 40), 0, 0);
        end
      end
      drain();
      ck("stall stream count", n_pop - p0, 20);

      // Accumulate burst of ones, then a fresh burst of twos.
      p0 = n_pop;
      send(fill(W'(1)), 1, 0);
      send(fill(W'(1)), 1, 0);
      repeat (LAT + 2) tick();
      ck("burst no early output", n_pop - p0, 0);
      send(fill(W'(1)), 1, 1);
      drain();
      ck("burst single output", n_pop - p0, 1);
      send(fill(W'(2)), 1, 0);
      send(fill(W'(2)), 1, 1);
      drain();

      // All-max burst of three (wraps when ACC_X=0).
      send(fill(WMAX), 1, 0);
      send(fill(WMAX), 1, 0);
      send(fill(WMAX), 1, 1);
      drain();

      // Reset after beat 2 of an open burst.
      send(fill(W'(1)), 1, 0);
      send(fill(W'(1)), 1, 0);
      rst_n = 0;
      #1;
      ck("reset mid out_valid", out_valid, 0);
      ck("reset mid sum", sum, 0);
      tick();
      rst_n = 1;
      acc_m = 0;
      exp_q.delete();
      p0 = n_pop;
      repeat (LAT + 3) tick();
      ck("no output after reset", n_pop - p0, 0);
      send(fill(W'(1)), 1, 0);
      send(fill(W'(1)), 1, 1);
      drain();

      // Random beats, gaps, bursts and backpressure.
      rnd_bp = 1;
      open = 0;
      for (int b = 0; b < 300; b++) begin
        if ($urandom_range(0, 3) == 0) tick();
        for (int i = 0; i < N; i++) x[i*W +: W] = W'($urandom);
        a = ($urandom_range(0, 2) == 0);
        l = $urandom_range(0, 1);
        send(x, a, l);
        if (a) open = !l;
      end
      if (open) send(fill(W'(1)), 1, 1);
      drain();
      n_done++;
    end
  end

  initial begin
    for (int t = 0; t < 60000; t++) begin
      @(posedge clk);
      if (n_done == NC) break;
    end
    if (n_done != NC) begin
      checks++;
      fails++;
      $display("FAIL global timeout: got %0d configs done, expected %0d", n_done, NC);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
